// File: rtl/psum_writeback.sv
// psum_writeback: drains completed OFIFO rows into the PSUM SRAM.
// Overwrite mode writes one row per cycle; accumulate mode does read-add-write.
module psum_writeback #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int ADDR_W  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     accumulate,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        num_rows,
    input  logic                     ofifo_valid,
    input  logic [psum_bw*col-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic [ADDR_W-1:0]        psum_mem_addr,
    output logic                     psum_mem_rd,
    output logic                     psum_mem_wr,
    output logic [psum_bw*col-1:0]   psum_mem_d,
    input  logic [psum_bw*col-1:0]   psum_mem_q,
    output logic                     busy,
    output logic                     done
);

    localparam int DW = psum_bw * col;

    typedef enum logic [2:0] {
        IDLE,
        OVR,
        ACC_RD,
        ACC_WR,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] rows_q;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nx;
    logic [DW-1:0]     hold;
    logic [DW-1:0]     sum;
    logic              last;

    assign last = (idx + ADDR_W'(1)) == rows_q;

    // Lane-wise wrapping add of the stored partial sum and the held OFIFO row.
    always_comb begin
        sum = '0;
        for (int i = 0; i < col; i++) begin
            sum[i*psum_bw +: psum_bw] =
                psum_mem_q[i*psum_bw +: psum_bw] + hold[i*psum_bw +: psum_bw];
        end
    end

    // Next-state and output decode; enables come only from the registered state.
    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        ofifo_rd      = 1'b0;
        psum_mem_rd   = 1'b0;
        psum_mem_wr   = 1'b0;
        psum_mem_d    = '0;
        done          = 1'b0;
        busy          = (state != IDLE);
        psum_mem_addr = base_q + idx;
        unique case (state)
            IDLE: begin
                if (start) begin
                    idx_nx = '0;
                    if (num_rows == '0) begin
                        state_nx = DONE;
                    end else if (accumulate) begin
                        state_nx = ACC_RD;
                    end else begin
                        state_nx = OVR;
                    end
                end
            end
            OVR: begin
                if (ofifo_valid) begin
                    ofifo_rd    = 1'b1;
                    psum_mem_wr = 1'b1;
                    psum_mem_d  = ofifo_out;
                    idx_nx      = idx + ADDR_W'(1);
                    if (last) begin
                        state_nx = DONE;
                    end
                end
            end
            ACC_RD: begin
                if (ofifo_valid) begin
                    ofifo_rd    = 1'b1;
                    psum_mem_rd = 1'b1;
                    state_nx    = ACC_WR;
                end
            end
            ACC_WR: begin
                psum_mem_wr = 1'b1;
                psum_mem_d  = sum;
                idx_nx      = idx + ADDR_W'(1);
                state_nx    = last ? DONE : ACC_RD;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, row index and pass parameters; parameters latch only from IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= '0;
            base_q <= '0;
            rows_q <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (state == IDLE && start) begin
                base_q <= base_addr;
                rows_q <= num_rows;
            end
        end
    end

    // Hold the popped OFIFO row until the SRAM read data returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold <= '0;
        end else if (state == ACC_RD && ofifo_valid) begin
            hold <= ofifo_out;
        end
    end

endmodule

// File: tb/tb_psum_writeback.sv
// tb_psum_writeback: randomized self-checking bench for psum_writeback.
// Behavioural OFIFO and SRAM models plus a per-row reference of expected writes.
module tb_psum_writeback;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 11;
    localparam int DW  = COL * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          accumulate = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_rows = '0;
    logic          ofifo_valid;
    logic [DW-1:0] ofifo_out;
    logic          ofifo_rd;
    logic [AW-1:0] psum_mem_addr;
    logic          psum_mem_rd;
    logic          psum_mem_wr;
    logic [DW-1:0] psum_mem_d;
    logic [DW-1:0] psum_mem_q;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    psum_writeback #(.col(COL), .psum_bw(BW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .accumulate   (accumulate),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .ofifo_valid  (ofifo_valid),
        .ofifo_out    (ofifo_out),
        .ofifo_rd     (ofifo_rd),
        .psum_mem_addr(psum_mem_addr),
        .psum_mem_rd  (psum_mem_rd),
        .psum_mem_wr  (psum_mem_wr),
        .psum_mem_d   (psum_mem_d),
        .psum_mem_q   (psum_mem_q),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, preload port for the bench
    logic [DW-1:0] sram [0:2047];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) sram[pl_addr] <= pl_data;
        else if (psum_mem_wr) sram[psum_mem_addr] <= psum_mem_d;
        if (psum_mem_rd) psum_mem_q <= sram[psum_mem_addr];
    end

    // OFIFO model: show-ahead array, bench pushes, DUT pops
    logic [DW-1:0] fifo [0:255];
    int            head = 0;
    int            tail = 0;
    logic          vld_en = 1'b1;

    assign ofifo_valid = (head != tail) && vld_en;
    assign ofifo_out   = fifo[head[7:0]];

    always @(posedge clk) begin
        if (ofifo_rd) head <= head + 1;
    end

    // Activity logs and enable-rule monitor
    logic [AW-1:0] wl_addr [$];
    logic [DW-1:0] wl_data [$];
    int            pops = 0;
    int            dones = 0;
    int            viol = 0;
    logic          prev_rd = 1'b0;

    always @(posedge clk) begin
        if (psum_mem_wr) begin
            wl_addr.push_back(psum_mem_addr);
            wl_data.push_back(psum_mem_d);
        end
        if (ofifo_rd) pops <= pops + 1;
        if (done) dones <= dones + 1;
        if ((psum_mem_rd && psum_mem_wr) ||
            (ofifo_rd && !ofifo_valid) ||
            (psum_mem_rd && !ofifo_rd) ||
            (psum_mem_wr && !ofifo_rd && !prev_rd))
            viol <= viol + 1;
        prev_rd <= psum_mem_rd;
    end

    // Reference model state
    logic [DW-1:0] exp_mem [0:2047];
    logic [AW-1:0] ex_addr [$];
    logic [DW-1:0] ex_data [$];

    function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < COL; i++)
            r[i*BW +: BW] = a[i*BW +: BW] + b[i*BW +: BW];
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        exp_mem[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic push_row(input logic [DW-1:0] row);
        fifo[tail % 256] = row;
        tail = tail + 1;
    endtask

    // Runs one pass from a negedge; reports timing and model discrepancies.
    task automatic drive_pass(input bit acc, input logic [AW-1:0] base,
                              input int n, input bit fixed,
                              input logic [DW-1:0] frow,
                              input int stall_at, input int stall_len,
                              input int poke,
                              output int cyc, output int wr_bad,
                              output int pop_cnt, output int done_cnt,
                              output int flag_bad);
        int w0;
        int p0;
        int d0;
        int budget;
        int stalled;
        int sc;
        int nw;
        logic [AW-1:0] a;
        logic [DW-1:0] row;
        w0 = wl_addr.size();
        p0 = pops;
        d0 = dones;
        ex_addr.delete();
        ex_data.delete();
        for (int r = 0; r < n; r++) begin
            row = fixed ? frow : rnd_row();
            push_row(row);
            a = base + AW'(r);
            exp_mem[a] = acc ? lane_add(exp_mem[a], row) : row;
            ex_addr.push_back(a);
            ex_data.push_back(exp_mem[a]);
        end
        budget = 4 * n + 40 + stall_len;
        flag_bad = 0;
        stalled = 0;
        sc = 0;
        start = 1'b1;
        accumulate = acc;
        base_addr = base;
        num_rows = AW'(n);
        @(negedge clk);
        start = 1'b0;
        accumulate = $urandom_range(0, 1);
        base_addr = AW'($urandom);
        num_rows = AW'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < budget) begin
            if (busy !== 1'b1) flag_bad++;
            if (poke > 0 && cyc == poke) begin
                start = 1'b1;
                accumulate = ~acc;
                base_addr = base + AW'(100);
                num_rows = AW'($urandom_range(1, 20));
            end else begin
                start = 1'b0;
            end
            if (stalled == 1) begin
                sc++;
                if (sc == stall_len) begin
                    vld_en = 1'b1;
                    stalled = 2;
                end
            end else if (stalled == 0 && stall_len > 0 &&
                         pops - p0 == stall_at) begin
                vld_en = 1'b0;
                stalled = 1;
                sc = 0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        vld_en = 1'b1;
        if (done !== 1'b1) cyc = -1;
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) flag_bad++;
        nw = wl_addr.size() - w0;
        wr_bad = (nw != n) ? 1 : 0;
        for (int i = 0; i < nw && i < n; i++) begin
            if (wl_addr[w0+i] !== ex_addr[i] || wl_data[w0+i] !== ex_data[i])
                wr_bad++;
            if (sram[ex_addr[i]] !== exp_mem[ex_addr[i]]) wr_bad++;
        end
        pop_cnt = pops - p0;
        done_cnt = dones - d0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({ofifo_rd, psum_mem_rd, psum_mem_wr, busy, done} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {ofifo_rd, psum_mem_rd, psum_mem_wr, busy, done});
        end
        n_cmp++;
        if (psum_mem_addr !== '0 || psum_mem_d !== '0) begin
            n_err++;
            $display("FAIL reset_data addr=%h d=%h want 0", psum_mem_addr,
                     psum_mem_d);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overwrite();
        int cyc, wb, pc, dc, fb;
        drive_pass(1'b0, 11'h010, 3, 1'b0, '0, 0, 0, 0, cyc, wb, pc, dc, fb);
        n_cmp++;
        if (cyc !== 4) begin
            n_err++;
            $display("FAIL ovr_cycles got %0d want 4", cyc);
        end
        n_cmp++;
        if (wb !== 0) begin
            n_err++;
            $display("FAIL ovr_writes bad=%0d want 0", wb);
        end
        n_cmp++;
        if (pc !== 3 || dc !== 1) begin
            n_err++;
            $display("FAIL ovr_pops pops=%0d dones=%0d want 3/1", pc, dc);
        end
        n_cmp++;
        if (fb !== 0) begin
            n_err++;
            $display("FAIL ovr_busy bad=%0d want 0", fb);
        end
    endtask

    task automatic test_accumulate();
        int cyc, wb, pc, dc, fb;
        preload(11'h020, {COL{16'd5}});
        @(negedge clk);
        drive_pass(1'b1, 11'h020, 1, 1'b1, {COL{16'd7}}, 0, 0, 0,
                   cyc, wb, pc, dc, fb);
        n_cmp++;
        if (sram[11'h020] !== {COL{16'd12}}) begin
            n_err++;
            $display("FAIL acc_sum got %h want %h", sram[11'h020],
                     {COL{16'd12}});
        end
        n_cmp++;
        if (cyc !== 3 || wb !== 0 || pc !== 1 || dc !== 1 || fb !== 0) begin
            n_err++;
            $display("FAIL acc_pass cyc=%0d wb=%0d pops=%0d dones=%0d fb=%0d want 3/0/1/1/0",
                     cyc, wb, pc, dc, fb);
        end
    endtask

    task automatic test_wrap();
        int cyc, wb, pc, dc, fb;
        int w0;
        preload(11'h7FF, {COL{16'h7FFF}});
        preload(11'h000, rnd_row());
        @(negedge clk);
        w0 = wl_addr.size();
        drive_pass(1'b1, 11'h7FF, 2, 1'b1, {COL{16'h0001}}, 0, 0, 0,
                   cyc, wb, pc, dc, fb);
        n_cmp++;
        if (sram[11'h7FF] !== {COL{16'h8000}}) begin
            n_err++;
            $display("FAIL wrap_ovf got %h want %h", sram[11'h7FF],
                     {COL{16'h8000}});
        end
        n_cmp++;
        if (wl_addr.size() < w0 + 2 || wl_addr[w0+1] !== 11'h000) begin
            n_err++;
            $display("FAIL wrap_addr writes=%0d want second at 000",
                     wl_addr.size() - w0);
        end
        n_cmp++;
        if (cyc !== 5 || wb !== 0 || pc !== 2) begin
            n_err++;
            $display("FAIL wrap_pass cyc=%0d wb=%0d pops=%0d want 5/0/2",
                     cyc, wb, pc);
        end
    endtask

    task automatic test_stall();
        int cyc, wb, pc, dc, fb;
        logic [AW-1:0] b;
        drive_pass(1'b0, 11'h100, 6, 1'b0, '0, 2, 4, 0, cyc, wb, pc, dc, fb);
        n_cmp++;
        if (cyc !== 11 || wb !== 0 || pc !== 6) begin
            n_err++;
            $display("FAIL stall_ovr cyc=%0d wb=%0d pops=%0d want 11/0/6",
                     cyc, wb, pc);
        end
        b = 11'h200;
        for (int r = 0; r < 5; r++) preload(b + AW'(r), rnd_row());
        @(negedge clk);
        drive_pass(1'b1, b, 5, 1'b0, '0, 2, 4, 0, cyc, wb, pc, dc, fb);
        n_cmp++;
        if (cyc < 0 || wb !== 0 || pc !== 5 || dc !== 1) begin
            n_err++;
            $display("FAIL stall_acc cyc=%0d wb=%0d pops=%0d dones=%0d want ok/0/5/1",
                     cyc, wb, pc, dc);
        end
    endtask

    task automatic test_zero_and_busy_start();
        int cyc, wb, pc, dc, fb;
        drive_pass(1'b0, 11'h300, 0, 1'b0, '0, 0, 0, 0, cyc, wb, pc, dc, fb);
        n_cmp++;
        if (cyc !== 1 || wb !== 0 || pc !== 0 || dc !== 1 || fb !== 0) begin
            n_err++;
            $display("FAIL zero_rows cyc=%0d wb=%0d pops=%0d dones=%0d fb=%0d want 1/0/0/1/0",
                     cyc, wb, pc, dc, fb);
        end
        drive_pass(1'b0, 11'h310, 4, 1'b0, '0, 0, 0, 2, cyc, wb, pc, dc, fb);
        n_cmp++;
        if (cyc !== 5 || wb !== 0 || pc !== 4 || dc !== 1 || fb !== 0) begin
            n_err++;
            $display("FAIL busy_start cyc=%0d wb=%0d pops=%0d dones=%0d fb=%0d want 5/0/4/1/0",
                     cyc, wb, pc, dc, fb);
        end
    endtask

    task automatic test_random();
        int cyc, wb, pc, dc, fb;
        int n, sl, sa, want;
        bit acc;
        logic [AW-1:0] b;
        for (int t = 0; t < 8; t++) begin
            acc = 1'($urandom_range(0, 1));
            b = AW'($urandom);
            n = $urandom_range(1, 10);
            sl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0;
            sa = $urandom_range(0, n - 1);
            if (acc)
                for (int r = 0; r < n; r++) preload(b + AW'(r), rnd_row());
            @(negedge clk);
            drive_pass(acc, b, n, 1'b0, '0, sa, sl, 0, cyc, wb, pc, dc, fb);
            want = acc ? 2 * n + 1 : n + 1;
            n_cmp++;
            if (wb !== 0 || pc !== n || dc !== 1 || fb !== 0 || cyc < 0) begin
                n_err++;
                $display("FAIL rand_%0d acc=%0d n=%0d wb=%0d pops=%0d dones=%0d fb=%0d cyc=%0d",
                         t, acc, n, wb, pc, dc, fb, cyc);
            end
            if (sl == 0) begin
                n_cmp++;
                if (cyc !== want) begin
                    n_err++;
                    $display("FAIL rand_cyc_%0d got %0d want %0d", t, cyc, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] b;
        logic [DW-1:0] orig2;
        logic [DW-1:0] row;
        int w0, p0, k;
        b = 11'h400;
        for (int r = 0; r < 4; r++) preload(b + AW'(r), rnd_row());
        orig2 = exp_mem[b + AW'(2)];
        for (int r = 0; r < 4; r++) begin
            row = rnd_row();
            push_row(row);
            if (r < 2) exp_mem[b + AW'(r)] = lane_add(exp_mem[b + AW'(r)], row);
        end
        @(negedge clk);
        w0 = wl_addr.size();
        p0 = pops;
        start = 1'b1;
        accumulate = 1'b1;
        base_addr = b;
        num_rows = 11'd4;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(wl_addr.size() - w0 == 2 && psum_mem_wr === 1'b1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 100) begin
            n_err++;
            $display("FAIL rst_mid_reach writes=%0d want 2 then ACC_WR",
                     wl_addr.size() - w0);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({ofifo_rd, psum_mem_rd, psum_mem_wr, busy, done} !== 5'b0 ||
            psum_mem_addr !== '0 || psum_mem_d !== '0) begin
            n_err++;
            $display("FAIL rst_mid_out ctl=%b addr=%h want all 0",
                     {ofifo_rd, psum_mem_rd, psum_mem_wr, busy, done},
                     psum_mem_addr);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wl_addr.size() - w0 !== 2 || pops - p0 !== 3) begin
            n_err++;
            $display("FAIL rst_mid_cnt writes=%0d pops=%0d want 2/3",
                     wl_addr.size() - w0, pops - p0);
        end
        n_cmp++;
        if (sram[b] !== exp_mem[b] || sram[b + AW'(1)] !== exp_mem[b + AW'(1)] ||
            sram[b + AW'(2)] !== orig2) begin
            n_err++;
            $display("FAIL rst_mid_mem row0=%h row2=%h want %h/%h",
                     sram[b], sram[b + AW'(2)], exp_mem[b], orig2);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || pops - p0 !== 3) begin
            n_err++;
            $display("FAIL rst_mid_idle busy=%b pops=%0d want 0/3", busy, pops - p0);
        end
    endtask

    task automatic test_enable_rules();
        n_cmp++;
        if (viol !== 0) begin
            n_err++;
            $display("FAIL enable_rules violations=%0d want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_overwrite();
        test_accumulate();
        test_wrap();
        test_stall();
        test_zero_and_busy_start();
        test_random();
        test_reset_mid();
        test_enable_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
